// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives a req/ack data port, stalls the pipeline until done, extends loads.
// Optional `MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of going to the bus.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic        MemWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic [2:0]  Funct3M,
   output logic        StallM,
   output logic [31:0] ReadDataM,
   output logic        BusErrM,
   output logic        MisalignM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic        we_q, err_q, mis_q;
   logic [3:0]  be_q;
   logic [2:0]  f3_q;
   logic [7:0]  cnt_q;

   logic        acc, trap, expired;
   logic [3:0]  be_in;
   logic [31:0] wdata_in, ld_ext;
   logic [1:0]  lane_sel;
   logic [15:0] lane;

   assign acc     = MemWriteM | (ResultSrcM == 2'b01);
   assign expired = (cnt_q == CntLast);

`ifdef MISALIGN_TRAP_EN
   assign trap = Funct3M[1] ? (|ALUResultM[1:0]) : (Funct3M[0] & ALUResultM[0]);
`else
   assign trap = 1'b0;
`endif

   // Funct3 bit 1 set selects a full word, which also covers the reserved encodings.
   always_comb begin
      be_in    = 4'b1111;
      wdata_in = WriteDataM;
      if (!Funct3M[1]) begin
         if (Funct3M[0]) begin
            be_in    = 4'b0011 << {ALUResultM[1], 1'b0};
            wdata_in = {2{WriteDataM[15:0]}};
         end else begin
            be_in    = 4'b0001 << ALUResultM[1:0];
            wdata_in = {4{WriteDataM[7:0]}};
         end
      end
   end

   always_comb begin
      lane_sel = f3_q[0] ? {addr_q[1], 1'b0} : addr_q[1:0];
      lane     = 16'(dmem_rdata >> {lane_sel, 3'b000});
      if (f3_q[1]) begin
         ld_ext = dmem_rdata;
      end else if (f3_q[0]) begin
         ld_ext = {{16{lane[15] & ~f3_q[2]}}, lane[15:0]};
      end else begin
         ld_ext = {{24{lane[7] & ~f3_q[2]}}, lane[7:0]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (acc) state_d = trap ? StDone : StBusy;
         StBusy:  if (dmem_ack || expired) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Stall is forced low while reset is held so an abandoned access releases the pipeline at once.
   always_comb begin
      StallM    = 1'b0;
      dmem_req  = 1'b0;
      BusErrM   = 1'b0;
      MisalignM = 1'b0;
      if (!reset) begin
         unique case (state_q)
            StIdle:  StallM = acc;
            StBusy:  begin
               StallM   = 1'b1;
               dmem_req = 1'b1;
            end
            StDone:  begin
               BusErrM   = err_q;
               MisalignM = mis_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         f3_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (acc) begin
                  addr_q  <= ALUResultM;
                  wdata_q <= wdata_in;
                  we_q    <= MemWriteM;
                  be_q    <= be_in;
                  f3_q    <= Funct3M;
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
                  mis_q   <= trap;
                  if (trap) rdata_q <= '0;
               end
            end
            StBusy: begin
               if (dmem_ack) begin
                  if (!we_q) rdata_q <= ld_ext;
               end else if (expired) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ReadDataM  = rdata_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = {addr_q[31:2], 2'b00};
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: random loads/stores against a behavioural memory-access model.
module tb_mem_stage_lsu;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ALUResultM, WriteDataM, ReadDataM, dmem_addr, dmem_wdata, dmem_rdata;
   logic        MemWriteM, StallM, BusErrM, MisalignM, dmem_req, dmem_we, dmem_ack;
   logic [1:0]  ResultSrcM;
   logic [2:0]  Funct3M;
   logic [3:0]  dmem_be;

   mem_stage_lsu #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .StallM(StallM),
      .ReadDataM(ReadDataM), .BusErrM(BusErrM), .MisalignM(MisalignM), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] rdata;
   } req_t;
   typedef struct {
      logic [31:0] rd;
      logic        err;
      logic        mis;
      int          stall;
   } resp_t;

   req_t        req_q[$];
   resp_t       resp_q[$];
   int          checks = 0;
   int          passed = 0;
   bit          quiet = 1'b1;
   logic [31:0] model_rd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic int size_of(input logic [2:0] f3);
      return f3[1] ? 4 : (f3[0] ? 2 : 1);
   endfunction

   function automatic int offset_of(input logic [2:0] f3, input logic [1:0] a);
      int sz = size_of(f3);
      return (sz == 4) ? 0 : int'(a) - (int'(a) % sz);
   endfunction

   function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] word);
      logic [31:0] sh = word >> (8 * offset_of(f3, a));
      byte         sb = sh[7:0];
      shortint     sh16 = sh[15:0];
      case (size_of(f3))
         1:       return f3[2] ? {24'b0, sh[7:0]} : 32'(int'(sb));
         2:       return f3[2] ? {16'b0, sh[15:0]} : 32'(int'(sh16));
         default: return word;
      endcase
   endfunction

   function automatic bit is_misaligned(input logic [2:0] f3, input logic [1:0] a);
`ifdef MISALIGN_TRAP_EN
      return (int'(a) % size_of(f3)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input int delay, input logic [31:0] rdata);
      req_t  rq;
      resp_t rs;
      int    sz = size_of(f3);
      int    n = 0;
      if (is_misaligned(f3, addr[1:0])) begin
         model_rd = '0;
         rs = '{rd: model_rd, err: 1'b0, mis: 1'b1, stall: 1};
      end else begin
         rq.addr  = {addr[31:2], 2'b00};
         rq.be    = (sz == 4) ? 4'hF : 4'(((1 << sz) - 1) << offset_of(f3, addr[1:0]));
         rq.we    = we;
         rq.wdata = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
         rq.delay = delay;
         rq.rdata = rdata;
         req_q.push_back(rq);
         if (delay >= int'(TO)) model_rd = '0;
         else if (!we) model_rd = load_value(f3, addr[1:0], rdata);
         rs = '{rd: model_rd, err: (delay >= int'(TO)), mis: 1'b0,
                stall: 1 + ((delay < int'(TO)) ? delay + 1 : int'(TO))};
      end
      resp_q.push_back(rs);
      @(posedge clk); #1;
      MemWriteM  = we;
      ResultSrcM = we ? 2'b00 : 2'b01;
      ALUResultM = addr;
      WriteDataM = wd;
      Funct3M    = f3;
      do begin
         @(posedge clk); #1;
         n++;
      end while (StallM && n < 60);
      if (StallM) check("stall_release", 32'(StallM), 32'd0);
      MemWriteM  = 1'b0;
      ResultSrcM = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
      repeat ($urandom_range(0, 2)) @(posedge clk);
   endtask

   // Memory responder: acks each request after its chosen delay, sprays stray acks when idle.
   initial begin
      int   rcnt = 0;
      req_t cur;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      cur = '{addr: '0, be: '0, we: 1'b0, wdata: '0, delay: 0, rdata: '0};
      forever begin
         @(posedge clk); #1;
         if (quiet) begin
            rcnt = 0;
         end else if (dmem_req) begin
            if (rcnt == 0) begin
               if (req_q.size() == 0) begin
                  checks++;
                  $display("FAIL req_unexpected: got request at %h, expected none", dmem_addr);
                  cur.delay = 0;
               end else begin
                  cur = req_q.pop_front();
                  check("req_addr", dmem_addr, cur.addr);
                  check("req_be", 32'(dmem_be), 32'(cur.be));
                  check("req_we", 32'(dmem_we), 32'(cur.we));
                  if (cur.we) check("req_wdata", dmem_wdata, cur.wdata);
               end
            end
            dmem_ack   = (rcnt == cur.delay);
            dmem_rdata = dmem_ack ? cur.rdata : $urandom;
            rcnt++;
         end else begin
            rcnt       = 0;
            dmem_ack   = ($urandom_range(0, 7) == 0);
            dmem_rdata = $urandom;
         end
      end
   end

   // Monitor: a falling stall marks a completed access; compare against the scoreboard.
   initial begin
      int    run = 0;
      resp_t rs;
      forever begin
         @(negedge clk);
         if (quiet || reset) begin
            run = 0;
         end else if (StallM) begin
            run++;
         end else if (run > 0) begin
            if (resp_q.size() == 0) begin
               checks++;
               $display("FAIL resp_unexpected: got completion, expected none");
            end else begin
               rs = resp_q.pop_front();
               check("read_data", ReadDataM, rs.rd);
               check("bus_err", 32'(BusErrM), 32'(rs.err));
               check("misalign", 32'(MisalignM), 32'(rs.mis));
               check("stall_cycles", 32'(run), 32'(rs.stall));
            end
            run = 0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          dly;
      logic [31:0] a;
      reset = 1'b1;
      MemWriteM = 1'b0; ResultSrcM = 2'b00; ALUResultM = '0; WriteDataM = '0; Funct3M = '0;
      #1;
      check("rst_stall", 32'(StallM), 32'd0);
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_rdata", ReadDataM, 32'd0);
      check("rst_buserr", 32'(BusErrM), 32'd0);
      check("rst_misalign", 32'(MisalignM), 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      quiet = 1'b0;

      issue(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 32'h0);
      issue(1'b0, 32'h103, 32'h0, 3'b000, 0, 32'h80123456);
      issue(1'b0, 32'h103, 32'h0, 3'b100, 1, 32'h80123456);
      issue(1'b0, 32'h102, 32'h0, 3'b001, 3, 32'h8001ABCD);
      issue(1'b0, 32'h204, 32'h0, 3'b010, 20, 32'h12345678);
      issue(1'b0, 32'h101, 32'h0, 3'b010, 0, 32'hCAFEF00D);
      issue(1'b1, 32'h101, 32'hA5A5C3C3, 3'b001, 7, 32'h0);
      issue(1'b0, 32'h102, 32'h0, 3'b101, 0, 32'hFFFF0000);

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 7))
            0:       dly = $urandom_range(TO, TO + 4);
            1:       dly = $urandom_range(4, TO - 1);
            default: dly = $urandom_range(0, 3);
         endcase
         a = $urandom;
         issue(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), dly, $urandom);
      end
      @(negedge clk);
      check("resp_drained", 32'(resp_q.size()), 32'd0);
      check("req_drained", 32'(req_q.size()), 32'd0);

      // Reset while an access is outstanding, then a late ack.
      quiet = 1'b1;
      @(posedge clk); #1;
      MemWriteM = 1'b0; ResultSrcM = 2'b01; ALUResultM = 32'h300; Funct3M = 3'b010;
      repeat (3) @(posedge clk);
      #2;
      check("mid_busy_req", 32'(dmem_req), 32'd1);
      reset = 1'b1;
      #1;
      check("rst_busy_req", 32'(dmem_req), 32'd0);
      check("rst_busy_stall", 32'(StallM), 32'd0);
      check("rst_busy_rdata", ReadDataM, 32'd0);
      ResultSrcM = 2'b00;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      dmem_rdata = 32'hFFFFFFFF;
      dmem_ack   = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("late_ack_rdata", ReadDataM, 32'd0);
      check("late_ack_stall", 32'(StallM), 32'd0);
      check("late_ack_req", 32'(dmem_req), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
